// File: rtl/oldland_ptw_if.sv
// oldland_ptw_if -- signal bundle between the page table walker, the MMU
// that starts walks and consumes TLB loads, and the memory bus it reads.
//
// Signals:
//   start, virt, ptbase         walk request from the MMU
//   m_addr, m_access            bus word read request (PTW drives)
//   m_ack, m_data, m_error      bus completion (bus drives)
//   load_data, load_virt,
//   load_phys                   TLB load strobes and data (PTW drives)
//   busy, done, fault           walk status (PTW drives)
//
// Modports:
//   master -- the walker
//   slave  -- the environment (MMU + bus)
interface oldland_ptw_if;
    logic        start;
    logic [31:12] virt;
    logic [31:12] ptbase;
    logic [31:2]  m_addr;
    logic        m_access;
    logic        m_ack;
    logic [31:0] m_data;
    logic        m_error;
    logic [31:0] load_data;
    logic        load_virt;
    logic        load_phys;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        input  start, virt, ptbase, m_ack, m_data, m_error,
        output m_addr, m_access, load_data, load_virt, load_phys,
               busy, done, fault
    );

    modport slave (
        output start, virt, ptbase, m_ack, m_data, m_error,
        input  m_addr, m_access, load_data, load_virt, load_phys,
               busy, done, fault
    );
endinterface

// File: rtl/oldland_ptw.sv
// oldland_ptw -- two-level hardware page table walker.
//
// On a start pulse it reads the level-1 PTE at {ptbase, virt[31:22]}, then
// the level-2 PTE at {l1_frame, virt[21:12]}, and loads the TLB with a
// virtual-tag write followed by a physical write. Invalid PTEs or bus errors
// end the walk with a one-cycle fault pulse and no TLB writes.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   oldland_ptw_if.master: start/virt/ptbase in, bus read master,
//         TLB load strobes, busy/done/fault status
//
// Configuration:
//   OLDLAND_PTW_SUPERPAGE_EN -- when defined, a valid L1 PTE with bit 5 set
//   is a 4 MB leaf and the L2 read is skipped.
module oldland_ptw (
    input  logic          clk,
    input  logic          rst,
    oldland_ptw_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_L1    = 3'd1;
    localparam logic [2:0] S_L2    = 3'd2;
    localparam logic [2:0] S_LOADV = 3'd3;
    localparam logic [2:0] S_LOADP = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [31:0] l1_pte_q, l1_pte_d;
    logic [31:0] l2_pte_q, l2_pte_d;

`ifdef OLDLAND_PTW_SUPERPAGE_EN
    logic superpage_q, superpage_d;
`endif

    // Leaf fields feeding the TLB load data.
    logic [3:0]  leaf_acc;
    logic [31:0] leaf_phys;

    // Next-state and PTE capture. Exit decisions look at m_data directly
    // since the PTE register only updates on the same edge.
    always_comb begin
        state_d  = state_q;
        l1_pte_d = l1_pte_q;
        l2_pte_d = l2_pte_q;
`ifdef OLDLAND_PTW_SUPERPAGE_EN
        superpage_d = superpage_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_L1;
`ifdef OLDLAND_PTW_SUPERPAGE_EN
                    superpage_d = 1'b0;
`endif
                end
            end
            S_L1: begin
                if (bus.m_ack) begin
                    l1_pte_d = bus.m_data;
                    if (bus.m_error || !bus.m_data[4]) begin
                        state_d = S_FAULT;
`ifdef OLDLAND_PTW_SUPERPAGE_EN
                    end else if (bus.m_data[5]) begin
                        state_d     = S_LOADV;
                        superpage_d = 1'b1;
`endif
                    end else begin
                        state_d = S_L2;
                    end
                end
            end
            S_L2: begin
                if (bus.m_ack) begin
                    l2_pte_d = bus.m_data;
                    if (bus.m_error || !bus.m_data[4]) state_d = S_FAULT;
                    else                               state_d = S_LOADV;
                end
            end
            S_LOADV: state_d = S_LOADP;
            S_LOADP: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Leaf selection: normally the L2 PTE; a superpage uses the L1 frame's
    // top 10 bits with the virtual page's low 10 bits passed through.
    always_comb begin
        leaf_acc  = l2_pte_q[3:0];
        leaf_phys = {l2_pte_q[31:12], 12'b0};
`ifdef OLDLAND_PTW_SUPERPAGE_EN
        if (superpage_q) begin
            leaf_acc  = l1_pte_q[3:0];
            leaf_phys = {l1_pte_q[31:22], bus.virt[21:12], 12'b0};
        end
`endif
    end

    // Outputs are decoded purely from state and captured PTEs.
    always_comb begin
        bus.m_access  = 1'b0;
        bus.m_addr    = '0;
        bus.load_virt = 1'b0;
        bus.load_phys = 1'b0;
        bus.load_data = '0;
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
        bus.fault     = (state_q == S_FAULT);
        case (state_q)
            S_L1: begin
                bus.m_access = 1'b1;
                bus.m_addr   = {bus.ptbase, bus.virt[31:22]};
            end
            S_L2: begin
                bus.m_access = 1'b1;
                bus.m_addr   = {l1_pte_q[31:12], bus.virt[21:12]};
            end
            S_LOADV: begin
                bus.load_virt = 1'b1;
                bus.load_data = {bus.virt, 8'b0, leaf_acc};
            end
            S_LOADP: begin
                bus.load_phys = 1'b1;
                bus.load_data = leaf_phys;
            end
            default: ;
        endcase
    end

    // PTE bits outside frame/valid/access are don't-care.
    logic unused_pte_bits;
    assign unused_pte_bits = ^{l1_pte_q[11:0], l2_pte_q[11:4]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            l1_pte_q <= '0;
            l2_pte_q <= '0;
`ifdef OLDLAND_PTW_SUPERPAGE_EN
            superpage_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            l1_pte_q <= l1_pte_d;
            l2_pte_q <= l2_pte_d;
`ifdef OLDLAND_PTW_SUPERPAGE_EN
            superpage_q <= superpage_d;
`endif
        end
    end

endmodule
